tamagotchi_btn_cond: RTL and testbench

Button conditioning front end for the tamagotchi pet FSM. It takes the raw, asynchronous, bouncing push-button levels (salud, energia, hambre, diversion, reset, test). For each one it produces a synchronized, debounced level, a single-cycle press pulse and a single-cycle long-press pulse, which the FSM consumes as clean events. It sits between the board pins and `tamagotchi_fsm`, one instance serving all buttons.

---
 rtl/tamagotchi_btn_cond_if.sv | 24 ++
 rtl/tamagotchi_btn_cond.sv | 105 ++++++++++
 tb/tb_tamagotchi_btn_cond.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tamagotchi_btn_cond_if.sv
// Button bundle between the board pins and the conditioning front end.
// The master drives raw levels; the slave returns the cleaned level and event pulses.
interface tamagotchi_btn_cond_if #(
    parameter int unsigned NUM_BTN = 6
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] long_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  long_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output long_pulse
    );
endinterface

// File: rtl/tamagotchi_btn_cond.sv
// Per-button synchronizer, debouncer, press and long-press pulse generator.
// Bit order 0..5: salud, energia, hambre, diversion, reset, test.
module tamagotchi_btn_cond #(
    parameter int unsigned NUM_BTN           = 6,
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned LONG_PRESS_CYCLES = 250000000
) (
    input  logic                  clk,
    input  logic                  reset,
    tamagotchi_btn_cond_if.slave  btn
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {StReleased, StPressed, StLongHeld} state_e;

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] lng;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        state_e          state_q, state_d;
        logic            s1_q, s2_q;
        logic [DW-1:0]   dcnt_q, dcnt_d;
        logic [HW-1:0]   hcnt_q, hcnt_d;
        logic            press_q, press_d;
        logic            long_q, long_d;
        logic            level_q;
        logic            rise, fall;

        // The debounced level is the state itself: anything but released reads as 1.
        assign level_q = (state_q != StReleased);

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= StReleased;
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                dcnt_q  <= '0;
                hcnt_q  <= '0;
                press_q <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                s1_q    <= btn.btn_raw[i];
                s2_q    <= s1_q;
                dcnt_q  <= dcnt_d;
                hcnt_q  <= hcnt_d;
                press_q <= press_d;
                long_q  <= long_d;
            end
        end

        always_comb begin
            dcnt_d  = '0;
            rise    = 1'b0;
            fall    = 1'b0;
            hcnt_d  = '0;
            long_d  = 1'b0;
            state_d = state_q;

            if (s2_q != level_q) begin
                if (dcnt_q == DEB_LAST) begin
                    rise = s2_q;
                    fall = !s2_q;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            // Hold time tracks the registered level, so a short low glitch keeps counting.
            if (level_q) begin
                hcnt_d = (hcnt_q == HOLD_MAX) ? hcnt_q : hcnt_q + 1'b1;
                long_d = (hcnt_q == HOLD_LAST);
            end

            press_d = rise;

            unique case (state_q)
                StReleased: if (rise) state_d = StPressed;
                StPressed: begin
                    if (fall) begin
                        state_d = StReleased;
                    end else if (long_d) begin
                        state_d = StLongHeld;
                    end
                end
                StLongHeld: if (fall) state_d = StReleased;
                default:    state_d = StReleased;
            endcase
        end

        assign level[i] = level_q;
        assign press[i] = press_q;
        assign lng[i]   = long_q;
    end

    assign btn.btn_level   = level;
    assign btn.press_pulse = press;
    assign btn.long_pulse  = lng;
endmodule

// File: tb/tb_tamagotchi_btn_cond.sv
// Directed test-plan scenarios plus randomized button activity against a cycle model.
module tb_tamagotchi_btn_cond;
    localparam int unsigned NB   = 6;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tamagotchi_btn_cond_if #(.NUM_BTN(NB)) bif ();

    tamagotchi_btn_cond #(
        .NUM_BTN          (NB),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (bif.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: raw sample history, run length of disagreement, cycles held.
    int m_s1[NB], m_s2[NB], m_lvl[NB], m_run[NB], m_held[NB];
    logic [NB-1:0] exp_level, exp_press, exp_long;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [NB-1:0] raw, input logic rst);
        for (int i = 0; i < NB; i++) begin
            if (rst) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_held[i] = 0;
                exp_press[i] = 1'b0;
                exp_long[i]  = 1'b0;
            end else begin
                exp_press[i] = 1'b0;
                exp_long[i]  = 1'b0;
                if (m_lvl[i] == 1) begin
                    m_held[i]++;
                    exp_long[i] = (m_held[i] == LONG);
                end else begin
                    m_held[i] = 0;
                end
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                        exp_press[i] = (m_lvl[i] == 1);
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(raw[i]);
            end
            exp_level[i] = (m_lvl[i] == 1);
        end
    endtask

    task automatic step(input logic [NB-1:0] raw, input logic rst);
        bif.btn_raw = raw;
        reset       = rst;
        @(posedge clk);
        model_update(raw, rst);
        @(negedge clk);
        check("level", 32'(bif.btn_level), 32'(exp_level));
        check("press", 32'(bif.press_pulse), 32'(exp_press));
        check("long", 32'(bif.long_pulse), 32'(exp_long));
    endtask

    initial begin
        int t, t2, np, nl, rate;
        logic [NB-1:0] raw;
        logic [NB-1:0] pat;

        bif.btn_raw = '0;
        reset       = 1'b1;
        step('0, 1'b1);
        step('0, 1'b1);
        check("reset_outputs", {bif.btn_level, bif.press_pulse, bif.long_pulse}, 32'd0);
        step('0, 1'b0);

        // Clean press on channel 0, then release.
        t = -1; np = 0;
        for (int k = 1; k <= 12; k++) begin
            step(6'b000001, 1'b0);
            if (bif.press_pulse[0]) begin np++; if (t < 0) t = k; end
            if (k >= 6) check("clean_level_high", 32'(bif.btn_level), 32'h1);
            else check("clean_level_low", 32'(bif.btn_level), 32'h0);
        end
        check("clean_press_step", t, 6);
        check("clean_press_count", np, 1);
        t = -1;
        for (int k = 1; k <= 10; k++) begin
            step('0, 1'b0);
            if (!bif.btn_level[0] && t < 0) t = k;
            check("release_no_press", 32'(bif.press_pulse), 32'h0);
        end
        check("clean_release_step", t, 6);

        // Short glitch on channel 2.
        np = 0;
        for (int k = 1; k <= 13; k++) begin
            step((k <= 3) ? 6'b000100 : 6'b000000, 1'b0);
            np += int'(bif.btn_level[2]) + int'(bif.press_pulse[2]) + int'(bif.long_pulse[2]);
        end
        check("glitch_quiet", np, 0);

        // Bounce on channel 3: toggles every 2 cycles, then holds high.
        t = -1; np = 0;
        for (int k = 1; k <= 40; k++) begin
            step((k > 10 || ((k - 1) % 4) < 2) ? 6'b001000 : 6'b000000, 1'b0);
            if (bif.press_pulse[3]) begin np++; if (t < 0) t = k; end
        end
        check("bounce_press_step", t, 14);
        check("bounce_press_count", np, 1);
        for (int k = 0; k < 10; k++) step('0, 1'b0);

        // Long press on channel 5 with a 2-cycle low glitch at cycle 15.
        t = -1; t2 = -1; np = 0; nl = 0;
        for (int k = 1; k <= 40; k++) begin
            step((k == 15 || k == 16) ? 6'b000000 : 6'b100000, 1'b0);
            if (bif.press_pulse[5]) begin np++; if (t < 0) t = k; end
            if (bif.long_pulse[5]) begin nl++; if (t2 < 0) t2 = k; end
        end
        check("long_press_step", t, 6);
        check("long_pulse_step", t2, 26);
        check("long_press_count", np, 1);
        check("long_pulse_count", nl, 1);
        for (int k = 0; k < 10; k++) step('0, 1'b0);

        // Simultaneous press on channels 1 and 3.
        for (int k = 1; k <= 8; k++) begin
            step(6'b001010, 1'b0);
            if (k == 6) check("simul_press", 32'(bif.press_pulse), 32'b001010);
            if (k == 7) check("simul_press_gone", 32'(bif.press_pulse), 32'h0);
        end
        for (int k = 0; k < 10; k++) step('0, 1'b0);

        // Reset while channel 4 is held.
        for (int k = 0; k < 8; k++) step(6'b010000, 1'b0);
        check("midpress_level", 32'(bif.btn_level), 32'b010000);
        step(6'b010000, 1'b1);
        check("midpress_reset", {bif.btn_level, bif.press_pulse, bif.long_pulse}, 32'd0);
        t = -1;
        for (int k = 1; k <= 10; k++) begin
            step(6'b010000, 1'b0);
            if (bif.press_pulse[4] && t < 0) t = k;
        end
        check("midpress_repress_step", t, 6);
        for (int k = 0; k < 10; k++) step('0, 1'b0);

        // Randomized activity: segments alternate between bouncy and steady buttons.
        raw = '0;
        for (int seg = 0; seg < 10; seg++) begin
            case ($urandom_range(0, 2))
                0: rate = 2;
                1: rate = 8;
                default: rate = 45;
            endcase
            for (int k = 0; k < 100; k++) begin
                pat = '0;
                for (int i = 0; i < NB; i++) pat[i] = ($urandom_range(0, rate - 1) == 0);
                raw = raw ^ pat;
                step(raw, ($urandom_range(0, 299) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
